digit_window_scroller: RTL and testbench
========================================

# digit_window_scroller

Parametrised digit-window selector between the BCD converter and the seven-segment multiplexer. It exposes a WIN_DIGITS-wide window of an NUM_DIGITS-digit BCD value on the display. The window scrolls one digit per BTNL/BTNR press, with input synchronisation, single-step edge detection, end-saturation or wrap mode, and one-hot position indicators for the LEDs. It generalises the fixed 3-of-5 display selector.

## Interface
Parameters:
- NUM_DIGITS, 5, number of BCD digits on bcd; must be ≥ WIN_DIGITS.
- WIN_DIGITS, 3, number of digits shown at once; must be ≥ 1.
- WRAP, 0, 0 = saturate at ends, 1 = wrap around.
- Derived: NUM_POS = NUM_DIGITS − WIN_DIGITS + 1.

Ports:
- clk  in  1  system clock; every register changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- bcd  in  4*NUM_DIGITS  BCD value; digit k is bcd[4k+3:4k], digit 0 is least significant.
- BTNL  in  1  raw (debounced, asynchronous) scroll-toward-MSD button.
- BTNR  in  1  raw scroll-toward-LSD button.
- window  out  4*WIN_DIGITS  displayed digits; nibble j = digit (pos + j), nibble 0 is rightmost on the display.
- pos_onehot  out  NUM_POS  bit pos set, others clear.
- at_min  out  1  pos == 0.
- at_max  out  1  pos == NUM_POS − 1.

## Operation
- State: pos register, range 0..NUM_POS−1, width max(1, clog2(NUM_POS)).
- Per button: two-flop synchroniser (s1, s2) and history flop (h). Pulse = s2 & ~h. All three flops reset to 1, so a button held through reset release produces no step.
- On a cycle with exactly one pulse:
  - Left pulse: pos + 1 if pos < NUM_POS − 1. At the max end, pos becomes 0 if WRAP = 1, else pos is unchanged.
  - Right pulse: pos − 1 if pos > 0. At the min end, pos becomes NUM_POS − 1 if WRAP = 1, else pos is unchanged.
- Both pulses in the same cycle: pos is unchanged. Neither pulse is queued.
- A held button produces one step only. It must be seen low after synchronisation (s2 = 0) for at least one cycle before it can step again.
- NUM_POS == 1: pos is constant 0 and buttons have no effect. at_min = at_max = 1.
- window, pos_onehot, at_min and at_max are combinational from the registered pos and the live bcd. No glitch filtering beyond this.
- Reset values: pos = 0, window = bcd[4*WIN_DIGITS−1:0], pos_onehot = 1, at_min = 1, at_max = (NUM_POS == 1).

## Timing
- Button sampled high at rising edge E1 (s1 = 1), E2 (s2 = 1, pulse high), E3 (pos updated, h = 1). window changes after E3: 3-cycle button-to-display latency.
- A press shorter than one clock period may be missed. A press that covers one rising edge is guaranteed to register one step.
- bcd changes appear on window in the same cycle (0 latency).
- rst assertion clears pos immediately (asynchronously), even mid-press. A pending pulse is discarded because its flops reset to 1.
- After rst deassertion, the first step is possible only after a button is sampled low and then high again.

## Test plan
- Reset with defaults, bcd = 20'h54321 → window = 12'h321, pos_onehot = 3'b001, at_min = 1, at_max = 0.
- BTNL held 1 cycle → window = 12'h432 exactly 3 clocks later. A second press → 12'h543, at_max = 1. A third press (WRAP = 0) → stays 12'h543.
- WRAP = 1 from pos 2: BTNL press → window = 12'h321, pos_onehot = 001. Then BTNR press → window = 12'h543, pos_onehot = 100.
- BTNL held 50 cycles → exactly one step. BTNL and BTNR rising in the same cycle → pos unchanged.
- BTNL held high across rst release → no step. Assert rst asynchronously mid-press at pos 1 → window = 12'h321 before the next clock edge.
- NUM_DIGITS = 8, WIN_DIGITS = 4: seven BTNL presses → pos = 4 (saturated), window = bcd[31:16]. NUM_DIGITS = WIN_DIGITS = 3: presses → window is always bcd, at_min = at_max = 1.

Source files
------------

// File: rtl/digit_window_scroller.sv
// rtl/digit_window_scroller.sv - scrollable WIN_DIGITS-of-NUM_DIGITS BCD display window
module digit_window_scroller #(
    parameter int NUM_DIGITS = 5,
    parameter int WIN_DIGITS = 3,
    parameter int WRAP       = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [4*NUM_DIGITS-1:0]         bcd,
    input  logic                            BTNL,
    input  logic                            BTNR,
    output logic [4*WIN_DIGITS-1:0]         window,
    output logic [NUM_DIGITS-WIN_DIGITS:0]  pos_onehot,
    output logic                            at_min,
    output logic                            at_max
);

    localparam int NUM_POS = NUM_DIGITS - WIN_DIGITS + 1;
    localparam int POS_W   = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
    localparam logic [POS_W-1:0] MAX_POS = POS_W'(NUM_POS - 1);

    logic [POS_W-1:0] pos;

    // Synchroniser and history flops; reset high so a button held through reset does not step
    logic l_s1, l_s2, l_h;
    logic r_s1, r_s2, r_h;
    logic pulse_l, pulse_r;

    // Two-flop synchronisers plus one history flop per button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_s1 <= 1'b1;
            l_s2 <= 1'b1;
            l_h  <= 1'b1;
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_h  <= 1'b1;
        end else begin
            l_s1 <= BTNL;
            l_s2 <= l_s1;
            l_h  <= l_s2;
            r_s1 <= BTNR;
            r_s2 <= r_s1;
            r_h  <= r_s2;
        end
    end

    assign pulse_l = l_s2 & ~l_h;
    assign pulse_r = r_s2 & ~r_h;

    // Window position: one step per isolated pulse, saturating or wrapping at the ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (NUM_POS > 1) begin
            if (pulse_l && !pulse_r) begin
                if (pos != MAX_POS) begin
                    pos <= pos + 1'b1;
                end else if (WRAP != 0) begin
                    pos <= '0;
                end
            end else if (pulse_r && !pulse_l) begin
                if (pos != '0) begin
                    pos <= pos - 1'b1;
                end else if (WRAP != 0) begin
                    pos <= MAX_POS;
                end
            end
        end
    end

    // Digit selection from live bcd and one-hot position decode
    always_comb begin
        window     = '0;
        pos_onehot = '0;
        for (int p = 0; p < NUM_POS; p++) begin
            if (pos == POS_W'(p)) begin
                pos_onehot[p] = 1'b1;
                for (int j = 0; j < WIN_DIGITS; j++) begin
                    window[4*j +: 4] = bcd[4*(p+j) +: 4];
                end
            end
        end
    end

    assign at_min = (pos == '0);
    assign at_max = (pos == MAX_POS);

endmodule

// File: tb/tb_digit_window_scroller.sv
// tb/tb_digit_window_scroller.sv - randomized self-checking bench for digit_window_scroller
module tb_digit_window_scroller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        BTNL = 1'b0;
    logic        BTNR = 1'b0;
    logic [19:0] bcd_a = 20'h54321;
    logic [19:0] bcd_b = 20'h54321;
    logic [31:0] bcd_c = 32'h87654321;
    logic [11:0] bcd_d = 12'h321;

    logic [11:0] win_a, win_b, win_d;
    logic [15:0] win_c;
    logic [2:0]  oh_a, oh_b;
    logic [4:0]  oh_c;
    logic [0:0]  oh_d;
    logic        mn_a, mn_b, mn_c, mn_d;
    logic        mx_a, mx_b, mx_c, mx_d;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    digit_window_scroller #(.NUM_DIGITS(5), .WIN_DIGITS(3), .WRAP(0)) dut_a (
        .clk(clk), .rst(rst), .bcd(bcd_a), .BTNL(BTNL), .BTNR(BTNR),
        .window(win_a), .pos_onehot(oh_a), .at_min(mn_a), .at_max(mx_a));
    digit_window_scroller #(.NUM_DIGITS(5), .WIN_DIGITS(3), .WRAP(1)) dut_b (
        .clk(clk), .rst(rst), .bcd(bcd_b), .BTNL(BTNL), .BTNR(BTNR),
        .window(win_b), .pos_onehot(oh_b), .at_min(mn_b), .at_max(mx_b));
    digit_window_scroller #(.NUM_DIGITS(8), .WIN_DIGITS(4), .WRAP(0)) dut_c (
        .clk(clk), .rst(rst), .bcd(bcd_c), .BTNL(BTNL), .BTNR(BTNR),
        .window(win_c), .pos_onehot(oh_c), .at_min(mn_c), .at_max(mx_c));
    digit_window_scroller #(.NUM_DIGITS(3), .WIN_DIGITS(3), .WRAP(0)) dut_d (
        .clk(clk), .rst(rst), .bcd(bcd_d), .BTNL(BTNL), .BTNR(BTNR),
        .window(win_d), .pos_onehot(oh_d), .at_min(mn_d), .at_max(mx_d));

    // Reference model: number of positions and wrap mode per instance
    int np [4] = '{3, 3, 5, 1};
    int wr [4] = '{0, 1, 0, 0};
    int mpos [4];
    bit lhist [3];
    bit rhist [3];

    // Button samples seen at the last three edges; a step lands two edges after a low-to-high sample pair
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) mpos[k] <= 0;
            lhist <= '{1'b1, 1'b1, 1'b1};
            rhist <= '{1'b1, 1'b1, 1'b1};
        end else begin
            bit sl, sr;
            sl = lhist[1] && !lhist[2];
            sr = rhist[1] && !rhist[2];
            for (int k = 0; k < 4; k++) begin
                if (sl && !sr) mpos[k] <= (mpos[k] + 1 < np[k]) ? mpos[k] + 1 : (wr[k] != 0 ? 0 : mpos[k]);
                else if (sr && !sl) mpos[k] <= (mpos[k] > 0) ? mpos[k] - 1 : (wr[k] != 0 ? np[k] - 1 : mpos[k]);
            end
            lhist <= '{BTNL, lhist[0], lhist[1]};
            rhist <= '{BTNR, rhist[0], rhist[1]};
        end
    end

    function automatic logic [15:0] exp_win(input logic [31:0] b, input int p, input int w);
        logic [15:0] r;
        r = '0;
        for (int j = 0; j < w; j++) r[4*j +: 4] = b[4*(p+j) +: 4];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        chk("win_a", 32'(win_a), 32'(exp_win(32'(bcd_a), mpos[0], 3)));
        chk("oh_a",  32'(oh_a),  32'(1) << mpos[0]);
        chk("min_a", 32'(mn_a),  32'(mpos[0] == 0));
        chk("max_a", 32'(mx_a),  32'(mpos[0] == np[0] - 1));
        chk("win_b", 32'(win_b), 32'(exp_win(32'(bcd_b), mpos[1], 3)));
        chk("oh_b",  32'(oh_b),  32'(1) << mpos[1]);
        chk("min_b", 32'(mn_b),  32'(mpos[1] == 0));
        chk("max_b", 32'(mx_b),  32'(mpos[1] == np[1] - 1));
        chk("win_c", 32'(win_c), 32'(exp_win(bcd_c, mpos[2], 4)));
        chk("oh_c",  32'(oh_c),  32'(1) << mpos[2]);
        chk("min_c", 32'(mn_c),  32'(mpos[2] == 0));
        chk("max_c", 32'(mx_c),  32'(mpos[2] == np[2] - 1));
        chk("win_d", 32'(win_d), 32'(exp_win(32'(bcd_d), mpos[3], 3)));
        chk("oh_d",  32'(oh_d),  32'(1));
        chk("minmax_d", {30'd0, mn_d, mx_d}, 32'd3);
    end

    task automatic press(input bit l, input bit r, input int len);
        @(negedge clk);
        BTNL = l;
        BTNR = r;
        repeat (len) @(negedge clk);
        BTNL = 1'b0;
        BTNR = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("lit_reset_win", 32'(win_a), 32'h321);
        chk("lit_reset_oh", 32'(oh_a), 32'b001);
        chk("lit_reset_minmax", {30'd0, mn_a, mx_a}, 32'b10);

        // Three-edge latency from a one-cycle press
        @(negedge clk);
        BTNL = 1'b1;
        @(posedge clk);
        @(negedge clk);
        BTNL = 1'b0;
        @(posedge clk);
        #1 chk("lit_lat_e2", 32'(win_a), 32'h321);
        @(posedge clk);
        #1 chk("lit_lat_e3", 32'(win_a), 32'h432);
        repeat (4) @(negedge clk);

        press(1, 0, 1);
        chk("lit_second_l", 32'(win_a), 32'h543);
        chk("lit_second_max", 32'(mx_a), 32'd1);
        press(1, 0, 1);
        chk("lit_sat_a", 32'(win_a), 32'h543);
        chk("lit_wrap_b", 32'(win_b), 32'h321);
        chk("lit_wrap_b_oh", 32'(oh_b), 32'b001);
        press(0, 1, 1);
        chk("lit_wrapr_b", 32'(win_b), 32'h543);
        chk("lit_wrapr_b_oh", 32'(oh_b), 32'b100);
        chk("lit_r_a", 32'(win_a), 32'h432);
        press(0, 1, 50);
        chk("lit_hold_b", 32'(win_b), 32'h432);
        chk("lit_hold_a", 32'(win_a), 32'h321);
        press(1, 1, 1);
        chk("lit_both_a", 32'(win_a), 32'h321);
        chk("lit_both_b", 32'(win_b), 32'h432);
        for (int i = 0; i < 7; i++) press(1, 0, 1);
        chk("lit_c_sat", 32'(win_c), 32'h8765);
        chk("lit_c_oh", 32'(oh_c), 32'b10000);
        chk("lit_d_win", 32'(win_d), 32'h321);

        // Button held across reset release must not step
        @(negedge clk);
        BTNL = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("lit_held_rst", 32'(win_a), 32'h321);
        BTNL = 1'b0;
        repeat (5) @(negedge clk);
        chk("lit_held_rel", 32'(win_a), 32'h321);

        // Asynchronous reset mid-press clears the position before the next edge
        press(1, 0, 1);
        chk("lit_pre_arst", 32'(win_a), 32'h432);
        @(negedge clk);
        BTNL = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("lit_arst", 32'(win_a), 32'h321);
        @(negedge clk);
        BTNL = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Random buttons and bcd
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) BTNL = ~BTNL;
            if ($urandom_range(0, 3) == 0) BTNR = ~BTNR;
            if ($urandom_range(0, 7) == 0) begin
                bcd_a = 20'($urandom);
                bcd_b = 20'($urandom);
                bcd_c = $urandom;
                bcd_d = 12'($urandom);
            end
            if (i == 300) rst = 1'b1;
            if (i == 303) rst = 1'b0;
        end
        BTNL = 1'b0;
        BTNR = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
